cpu_oci_dct_unpack: RTL and testbench

Consumer end of the OCI debug compressed-trace (DCT) path. The OCI packer accumulates 2-bit trace codes into a 30-bit `dct_buffer` with a 4-bit `dct_count` of valid codes. This block accepts those packed words through a valid/ready handshake and re-serialises them into one 2-bit code per cycle for the trace sink. It also drains cleanly at end of test and reports `test_has_ended`.

---
 rtl/cpu_oci_dct_pkg.sv | 15 +
 rtl/cpu_oci_dct_unpack.sv | 96 +++++++++
 tb/tb_cpu_oci_dct_unpack.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_oci_dct_pkg.sv
// Shared definitions for the OCI compressed-trace (DCT) path.
package cpu_oci_dct_pkg;

    localparam int unsigned CODE_W = 2;
    localparam int unsigned SLOTS  = 15;
    localparam int unsigned BUF_W  = 30;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ENDED
    } state_t;

endpackage

// File: rtl/cpu_oci_dct_unpack.sv
// Re-serialises packed DCT words into one trace code per cycle and
// drains/stops on a test-ending request.
module cpu_oci_dct_unpack
    import cpu_oci_dct_pkg::*;
#(
    parameter int unsigned CODE_W  = 2,
    parameter int unsigned SLOTS   = 15,
    parameter int unsigned TOTAL_W = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CODE_W*SLOTS-1:0]   dct_buffer,
    input  logic [CNT_W-1:0]          dct_count,
    input  logic                      dct_valid,
    output logic                      dct_ready,
    output logic [CODE_W-1:0]         code,
    output logic                      code_valid,
    input  logic                      code_ready,
    input  logic                      test_ending,
    output logic                      test_has_ended,
    output logic [TOTAL_W-1:0]        code_total
);

    localparam int unsigned W = CODE_W * SLOTS;

    state_t             state, state_nx;
    logic [W-1:0]       shreg, shreg_nx;
    logic [CNT_W-1:0]   remaining, remaining_nx;
    logic               ending_seen;
    logic               code_xfer;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            shreg       <= '0;
            remaining   <= '0;
            ending_seen <= 1'b0;
            code_total  <= '0;
        end else begin
            state       <= state_nx;
            shreg       <= shreg_nx;
            remaining   <= remaining_nx;
            ending_seen <= ending_seen | test_ending;
            if (code_xfer)
                code_total <= code_total + TOTAL_W'(1);
        end
    end

    // A count-0 word is handshaken but never loaded, so the state path
    // (IDLE stays IDLE, last-code SHIFT falls to IDLE) is unaffected by it.
    always_comb begin
        state_nx     = state;
        shreg_nx     = shreg;
        remaining_nx = remaining;
        dct_ready    = 1'b0;
        case (state)
            IDLE: begin
                dct_ready = 1'b1;
                if (dct_valid) begin
                    if (dct_count != '0) begin
                        shreg_nx     = dct_buffer;
                        remaining_nx = dct_count;
                        state_nx     = SHIFT;
                    end
                end else if (ending_seen | test_ending) begin
                    state_nx = ENDED;
                end
            end
            SHIFT: begin
                if (code_ready) begin
                    if (remaining == CNT_W'(1)) begin
                        dct_ready = 1'b1;
                        if (dct_valid && dct_count != '0) begin
                            shreg_nx     = dct_buffer;
                            remaining_nx = dct_count;
                        end else begin
                            shreg_nx     = shreg >> CODE_W;
                            remaining_nx = '0;
                            state_nx     = IDLE;
                        end
                    end else begin
                        shreg_nx     = shreg >> CODE_W;
                        remaining_nx = remaining - CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    assign code_valid     = (state == SHIFT);
    assign code           = shreg[CODE_W-1:0];
    assign test_has_ended = (state == ENDED);
    assign code_xfer      = code_valid & code_ready;

endmodule

// File: tb/tb_cpu_oci_dct_unpack.sv
// Self-checking bench for cpu_oci_dct_unpack: queue-based reference model
// plus directed literal checks.
module tb_cpu_oci_dct_unpack;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [29:0] dct_buffer = '0;
    logic [3:0]  dct_count = '0;
    logic        dct_valid = 1'b0;
    logic        dct_ready;
    logic [1:0]  code;
    logic        code_valid;
    logic        code_ready = 1'b0;
    logic        test_ending = 1'b0;
    logic        test_has_ended;
    logic [15:0] code_total;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    cpu_oci_dct_unpack #(.CODE_W(2), .SLOTS(15), .TOTAL_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .dct_buffer(dct_buffer), .dct_count(dct_count),
        .dct_valid(dct_valid), .dct_ready(dct_ready),
        .code(code), .code_valid(code_valid), .code_ready(code_ready),
        .test_ending(test_ending), .test_has_ended(test_has_ended),
        .code_total(code_total)
    );

    always #5 clk = ~clk;

    // Reference model: a queue holding the codes still to be emitted.
    logic [1:0]  m_q[$];
    bit          m_ended = 0;
    bit          m_seen  = 0;
    logic [15:0] m_total = '0;

    function automatic bit m_valid();
        return !m_ended && m_q.size() > 0;
    endfunction

    function automatic bit m_ready();
        return !m_ended && (m_q.size() == 0 || (m_q.size() == 1 && code_ready));
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_ended = 0;
            m_seen  = 0;
            m_total = '0;
        end else begin
            bit idle, rdy, vld;
            idle = !m_ended && m_q.size() == 0;
            rdy  = m_ready();
            vld  = m_valid();
            if (vld && code_ready) begin
                void'(m_q.pop_front());
                m_total = m_total + 16'd1;
            end
            if (dct_valid && rdy && dct_count != 0) begin
                m_q.delete();
                for (int k = 0; k < int'(dct_count); k++)
                    m_q.push_back(dct_buffer[2*k +: 2]);
            end
            if (idle && !dct_valid && (m_seen || test_ending))
                m_ended = 1;
            m_seen = m_seen | test_ending;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the clock edge.
    always begin
        @(negedge clk);
        #2;
        chk("code_valid", 32'(code_valid), 32'(m_valid()));
        if (m_valid())
            chk("code", 32'(code), 32'(m_q[0]));
        chk("dct_ready", 32'(dct_ready), 32'(m_ready()));
        chk("test_has_ended", 32'(test_has_ended), 32'(m_ended));
        chk("code_total", 32'(code_total), 32'(m_total));
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        dct_valid = 1'b0;
        test_ending = 1'b0;
        #1;
        chk("rst_code", 32'(code), 32'd0);
        chk("rst_code_valid", 32'(code_valid), 32'd0);
        chk("rst_dct_ready", 32'(dct_ready), 32'd1);
        chk("rst_has_ended", 32'(test_has_ended), 32'd0);
        chk("rst_total", 32'(code_total), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Presents a word and returns once it has been accepted on a rising edge.
    task automatic put_word(input logic [29:0] b, input logic [3:0] c, output int unsigned waits);
        waits = 0;
        @(negedge clk);
        dct_buffer = b;
        dct_count  = c;
        dct_valid  = 1'b1;
        #1;
        while (!dct_ready && waits < 200) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (!dct_ready) begin
            chk("word_accept_timeout", 32'(dct_ready), 32'd1);
        end else begin
            @(posedge clk);
        end
    endtask

    initial begin : timeout
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int unsigned w;
        logic [1:0]  exp_codes [4];
        logic [15:0] saved;
        exp_codes[0] = 2'd3; exp_codes[1] = 2'd2; exp_codes[2] = 2'd1; exp_codes[3] = 2'd0;

        do_reset();

        // Single word 0x1B, count 4: codes 3,2,1,0.
        code_ready = 1'b1;
        put_word(30'h1B, 4'd4, w);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dct_valid = 1'b0;
            #3;
            chk("single_valid", 32'(code_valid), 32'd1);
            chk("single_code", 32'(code), 32'(exp_codes[i]));
        end
        @(negedge clk);
        #3;
        chk("single_idle", 32'(code_valid), 32'd0);
        chk("single_total", 32'(code_total), 32'd4);

        // Back-to-back count-15 words.
        put_word(30'($urandom), 4'd15, w);
        put_word(30'($urandom), 4'd15, w);
        chk("b2b_word1_cycles", 32'(w), 32'd14);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            dct_valid = 1'b0;
            #3;
            chk("b2b_valid", 32'(code_valid), 32'd1);
        end
        @(negedge clk);
        #3;
        chk("b2b_end", 32'(code_valid), 32'd0);
        chk("b2b_total", 32'(code_total), 32'd34);

        // Count 0 word is dropped.
        saved = m_total;
        put_word(30'($urandom), 4'd0, w);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dct_valid = 1'b0;
            #3;
            chk("cnt0_valid", 32'(code_valid), 32'd0);
            chk("cnt0_total", 32'(code_total), 32'(saved));
        end

        // Backpressure: codes 0,1,2,3,0,... ; stall 5 cycles on code 3.
        put_word(30'h24E4E4E4, 4'd15, w);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dct_valid = 1'b0;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            code_ready = 1'b0;
            #3;
            chk("bp_valid", 32'(code_valid), 32'd1);
            chk("bp_code", 32'(code), 32'd3);
        end
        @(negedge clk);
        code_ready = 1'b1;
        repeat (14) @(negedge clk);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            dct_valid  = ($urandom % 3) != 0;
            dct_buffer = 30'($urandom);
            dct_count  = 4'($urandom % 16);
            code_ready = ($urandom % 4) != 0;
        end
        @(negedge clk);
        dct_valid  = 1'b0;
        code_ready = 1'b1;
        repeat (20) @(negedge clk);

        // End of test while 3 codes remain.
        put_word(30'($urandom), 4'd5, w);
        @(negedge clk);
        dct_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        test_ending = 1'b1;
        #3;
        chk("end_valid0", 32'(code_valid), 32'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            test_ending = 1'b0;
            #3;
            chk("end_valid", 32'(code_valid), 32'd1);
        end
        @(negedge clk);
        #3;
        chk("end_idle", 32'(code_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            dct_valid = 1'b1;
            dct_count = 4'd7;
            #3;
            chk("ended_flag", 32'(test_has_ended), 32'd1);
            chk("ended_ready", 32'(dct_ready), 32'd0);
            chk("ended_valid", 32'(code_valid), 32'd0);
        end
        @(negedge clk);
        dct_valid = 1'b0;

        // Asynchronous reset mid-word.
        do_reset();
        put_word(30'($urandom), 4'd10, w);
        @(negedge clk);
        dct_valid = 1'b0;
        @(negedge clk);
        #4;
        reset_n = 1'b0;
        #1;
        chk("arst_code_valid", 32'(code_valid), 32'd0);
        chk("arst_code", 32'(code), 32'd0);
        chk("arst_ready", 32'(dct_ready), 32'd1);
        chk("arst_total", 32'(code_total), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Counter wrap: 65535 + 2 codes.
        do_reset();
        code_ready = 1'b1;
        for (int i = 0; i < 4369; i++)
            put_word(30'($urandom), 4'd15, w);
        put_word(30'($urandom), 4'd2, w);
        @(negedge clk);
        dct_valid = 1'b0;
        repeat (20) @(negedge clk);
        #3;
        chk("wrap_total", 32'(code_total), 32'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
